// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, glyph table and digit index type for the time display
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns, bit 7 is the decimal point (1 = dark)
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Clearing bit 7 lights the decimal point
  localparam logic [7:0] DP_MASK   = 8'h7F;

  typedef logic [2:0] digit_idx_t;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_99.sv
// rtl/bin2bcd_99.sv - splits an 8-bit value 0..99 into tens/ones, flags values above 99
module bin2bcd_99 (
  input  logic [7:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       overflow
);

  // tens/ones are meaningless when overflow is set; the caller shows a dash instead
  assign overflow = (value > 8'd99);
  assign tens     = 4'(value / 8'd10);
  assign ones     = 4'(value % 8'd10);

endmodule

// File: rtl/seg7_time_display.sv
// rtl/seg7_time_display.sv - six-digit multiplexed hh.mm.ss driver with setup-field blinking
module seg7_time_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] data,
  input  logic [1:0]  setup_rezhim,
  output logic [7:0]  seg,
  output logic [5:0]  an
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_TC  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_DIV - 1);
  localparam digit_idx_t         LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  digit_idx_t         digit_idx;
  logic [23:0]        snap;
  logic               first_load;
  logic               phase;
  logic [1:0]         rezhim_q;

  logic scan_tick;
  logic frame_wrap;
  logic rezhim_chg;

  assign scan_tick  = (scan_cnt == SCAN_TC);
  assign frame_wrap = scan_tick && (digit_idx == LAST_DIGIT);
  assign rezhim_chg = (setup_rezhim != rezhim_q);

  // Scan prescaler and digit index, advancing one digit per terminal count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_tick) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == LAST_DIGIT) ? digit_idx_t'(0) : digit_idx + digit_idx_t'(1);
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

  // Snapshot of the time word, taken once after reset and at every frame wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap       <= '0;
      first_load <= 1'b1;
    end else begin
      first_load <= 1'b0;
      if (first_load || frame_wrap) begin
        snap <= data;
      end
    end
  end

  // Blink phase; a field change restarts the visible half so the new field shows at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
      rezhim_q  <= '0;
    end else begin
      rezhim_q <= setup_rezhim;
      if (rezhim_chg) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt == BLINK_TC) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  logic [7:0] field_val;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       overflow;
  logic [7:0] seg_next;
  logic [5:0] an_next;
  logic       blank;
  logic       visible;

  // Pick the byte of the snapshot that feeds the current digit pair
  always_comb begin
    field_val = snap[23:16];
    case (digit_idx[2:1])
      2'd0:    field_val = snap[7:0];
      2'd1:    field_val = snap[15:8];
      default: field_val = snap[23:16];
    endcase
  end

  bin2bcd_99 u_bin2bcd (
    .value    (field_val),
    .tens     (tens),
    .ones     (ones),
    .overflow (overflow)
  );

  // Glyph, separator dots and blanking for the digit about to be shown
  always_comb begin
    // The change cycle itself already counts as visible, matching the forced phase
    visible  = phase || rezhim_chg;
    blank    = (setup_rezhim != 2'd0) && !visible &&
               (setup_rezhim == (digit_idx[2:1] + 2'd1));
    seg_next = overflow ? SEG_DASH : glyph(digit_idx[0] ? tens : ones);
    if (digit_idx == digit_idx_t'(2) || digit_idx == digit_idx_t'(4)) begin
      seg_next = seg_next & DP_MASK;
    end
    an_next  = ~(6'b000001 << digit_idx);
    if (blank) begin
      seg_next = SEG_BLANK;
      an_next  = 6'h3F;
    end
  end

  // Registered outputs, held dark until the first snapshot has been taken
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg <= SEG_BLANK;
      an  <= 6'h3F;
    end else if (first_load) begin
      seg <= SEG_BLANK;
      an  <= 6'h3F;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule
